imaging_core: RTL and testbench

- APB-controlled capture engine for a row/column-addressed analog image sensor (resp/resv/incp/incv/inphi control) digitised by four 1-bit serial ADCs sharing one chip-select and SCLK.
- A CPU start command scans one frame. Each pixel's four samples are packed into a 32-bit word and pushed to an internal FIFO (cam0). The CPU drains the FIFO over APB.
- Test-point outputs expose the FIFO and FSM state.

---
 rtl/imaging_core_if.sv | 21 ++
 rtl/imaging_core.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_imaging_core.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imaging_core_if.sv
// APB3 bus bundle between a CPU-side requester and the imaging_core register block.
interface imaging_core_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/imaging_core.sv
// Generic show-ahead FIFO with flush; flush and a write in the same cycle keep the write.
// Latency: a written word is visible on rd_dat the cycle after the write.
// Backpressure: writes while full and reads while empty are ignored; callers gate on full/empty.
module imaging_core_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty && !flush;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_wr ? nxt('0) : '0;
            level  <= do_wr ? LW'(1) : '0;
        end else begin
            if (do_wr)
                wr_ptr <= nxt(wr_ptr);
            if (do_rd)
                rd_ptr <= nxt(rd_ptr);
            if (do_wr && !do_rd)
                level <= level + LW'(1);
            else if (!do_wr && do_rd)
                level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[flush ? '0 : wr_ptr] <= wr_dat;
    end
endmodule

// APB-controlled frame capture: sequences the sensor, reads four serial ADCs, packs pixels into cam0.
// Latency: one pixel every SETTLE+CONV+STORE(+INCV) cycles; APB reads complete with zero wait states.
// Backpressure: the FSM holds in STORE while cam0 is full, so no pixel is ever dropped.
module imaging_core #(
    parameter int NUM_ROWS   = 112,
    parameter int NUM_COLS   = 112,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 4,
    parameter int SCLK_DIV   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    imaging_core_if.slave        apb,
    input  logic                 px0_adc_din,
    input  logic                 px1_adc_din,
    input  logic                 px2_adc_din,
    input  logic                 px3_adc_din,
    input  logic                 clk_px_read,
    output logic                 px_adc_cs,
    output logic                 px_adc_sclk,
    output logic                 resp,
    output logic                 resv,
    output logic                 incp,
    output logic                 incv,
    output logic                 inphi,
    output logic                 tp_startcap,
    output logic                 tp_busy,
    output logic                 tp_wren,
    output logic                 tp_cam0_rden,
    output logic                 tp_cam0_full,
    output logic                 tp_cam0_empty,
    output logic                 tp_cam0_afull,
    output logic [3:0]           tp_stateout,
    output logic [4:0]           tp_substateout,
    output logic [3:0]           TP_REG_OFFSET_UPPER_NIBBLE
);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam logic [4:0]    PULSE_LAST  = 5'(PULSE_CYC-1);
    localparam logic [4:0]    SETTLE_LAST = 5'(SETTLE_CYC-1);
    localparam logic [7:0]    DIV_LAST    = 8'(SCLK_DIV-1);
    localparam logic [15:0]   COL_LAST    = 16'(NUM_COLS-1);
    localparam logic [15:0]   ROW_LAST    = 16'(NUM_ROWS-1);
    localparam logic [LW-1:0] AFULL_LVL   = LW'(FIFO_DEPTH-4);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RESP   = 4'd1,
        ST_RESV   = 4'd2,
        ST_SETTLE = 4'd3,
        ST_CONV   = 4'd4,
        ST_STORE  = 4'd5,
        ST_INCV   = 4'd6,
        ST_INCP   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    state_t        state;
    logic [4:0]    cnt;
    logic [7:0]    div_cnt;
    logic [15:0]   col;
    logic [15:0]   row;
    logic [31:0]   pixcnt;
    logic [15:0]   s0, s1, s2, s3;

    logic          access;
    logic [7:0]    offset;
    logic          ctrl_wr;
    logic          start_req;
    logic          flush_req;
    logic [31:0]   fifo_dat;
    logic [LW-1:0] fifo_level;
    logic [31:0]   prdata;
    logic          pslverr;
    logic          unused_bits;

    assign access    = apb.PSEL && apb.PENABLE;
    assign offset    = apb.PADDR[7:0];
    assign ctrl_wr   = access && apb.PWRITE && (offset == 8'h00);
    assign start_req = ctrl_wr && apb.PWDATA[0];
    assign flush_req = ctrl_wr && apb.PWDATA[1];

    assign tp_cam0_rden  = access && !apb.PWRITE && (offset == 8'h04) && !tp_cam0_empty;
    assign tp_wren       = (state == ST_STORE) && !tp_cam0_full;
    assign tp_busy       = (state != ST_IDLE);
    assign tp_cam0_afull = (fifo_level >= AFULL_LVL);
    assign tp_stateout   = state;
    assign tp_substateout = cnt;
    assign TP_REG_OFFSET_UPPER_NIBBLE = apb.PADDR[7:4];

    assign apb.PREADY  = 1'b1;
    assign apb.PRDATA  = prdata;
    assign apb.PSLVERR = pslverr;

    assign unused_bits = ^{clk_px_read, apb.PADDR[31:8], apb.PWDATA[31:2],
                           s0[15:12], s0[3:0], s1[15:12], s1[3:0],
                           s2[15:12], s2[3:0], s3[15:12], s3[3:0]};

    imaging_core_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_cam0 (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush_req),
        .wr_vld (tp_wren),
        .wr_dat ({s3[11:4], s2[11:4], s1[11:4], s0[11:4]}),
        .rd_rdy (tp_cam0_rden),
        .rd_dat (fifo_dat),
        .level  (fifo_level),
        .full   (tp_cam0_full),
        .empty  (tp_cam0_empty)
    );

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access) begin
            case (offset)
                8'h00: if (!apb.PWRITE)
                           prdata = {28'd0, tp_cam0_afull, tp_cam0_full, tp_cam0_empty, tp_busy};
                8'h04: if (apb.PWRITE || tp_cam0_empty) pslverr = 1'b1;
                       else                              prdata  = fifo_dat;
                8'h08: if (apb.PWRITE) pslverr = 1'b1;
                       else            prdata  = 32'(fifo_level);
                8'h0C: if (apb.PWRITE) pslverr = 1'b1;
                       else            prdata  = pixcnt;
                default: pslverr = 1'b1;
            endcase
        end
    end

    // Each pulse output is raised on entry to its state and dropped on exit,
    // so it is high for exactly the cycles spent in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            div_cnt     <= '0;
            col         <= '0;
            row         <= '0;
            pixcnt      <= '0;
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            px_adc_cs   <= 1'b1;
            px_adc_sclk <= 1'b1;
            resp        <= 1'b0;
            resv        <= 1'b0;
            incp        <= 1'b0;
            incv        <= 1'b0;
            inphi       <= 1'b0;
            tp_startcap <= 1'b0;
        end else begin
            tp_startcap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state       <= ST_RESP;
                        tp_startcap <= 1'b1;
                        resp        <= 1'b1;
                        inphi       <= 1'b1;
                        cnt         <= '0;
                        col         <= '0;
                        row         <= '0;
                        pixcnt      <= '0;
                    end
                end
                ST_RESP: begin
                    if (cnt == PULSE_LAST) begin
                        resp  <= 1'b0;
                        inphi <= 1'b0;
                        resv  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_RESV;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_RESV: begin
                    if (cnt == PULSE_LAST) begin
                        resv  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt       <= '0;
                        div_cnt   <= '0;
                        px_adc_cs <= 1'b0;
                        state     <= ST_CONV;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_CONV: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt     <= '0;
                        px_adc_sclk <= !px_adc_sclk;
                        // SCLK currently low: this toggle is a rising edge, sample now.
                        if (!px_adc_sclk) begin
                            s0 <= {s0[14:0], px0_adc_din};
                            s1 <= {s1[14:0], px1_adc_din};
                            s2 <= {s2[14:0], px2_adc_din};
                            s3 <= {s3[14:0], px3_adc_din};
                            if (cnt == 5'd15) begin
                                cnt       <= '0;
                                px_adc_cs <= 1'b1;
                                state     <= ST_STORE;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_STORE: begin
                    if (!tp_cam0_full) begin
                        pixcnt <= pixcnt + 32'd1;
                        cnt    <= '0;
                        if (col != COL_LAST) begin
                            col   <= col + 16'd1;
                            incv  <= 1'b1;
                            state <= ST_INCV;
                        end else begin
                            col <= '0;
                            if (row != ROW_LAST) begin
                                row   <= row + 16'd1;
                                incp  <= 1'b1;
                                state <= ST_INCP;
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_INCV: begin
                    if (cnt == PULSE_LAST) begin
                        incv  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_INCP: begin
                    if (cnt == PULSE_LAST) begin
                        incp  <= 1'b0;
                        resv  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_RESV;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imaging_core.sv
// Directed bench for imaging_core on a 5x5 frame: sensor/ADC model, FIFO level model and APB scoreboard.
module tb_imaging_core;
    localparam int ROWS   = 5;
    localparam int COLS   = 5;
    localparam int PULSE  = 2;
    localparam int SETTLE = 4;
    localparam int DIV    = 1;
    localparam int DEPTH  = 16;
    localparam int NPIX   = ROWS * COLS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic px0_adc_din = 1'b0, px1_adc_din = 1'b0, px2_adc_din = 1'b0, px3_adc_din = 1'b0;
    logic px_adc_cs, px_adc_sclk, resp, resv, incp, incv, inphi;
    logic tp_startcap, tp_busy, tp_wren, tp_cam0_rden, tp_cam0_full, tp_cam0_empty, tp_cam0_afull;
    logic [3:0] tp_stateout;
    logic [4:0] tp_substateout;
    logic [3:0] tp_nibble;

    imaging_core_if apb();

    imaging_core #(
        .NUM_ROWS(ROWS), .NUM_COLS(COLS), .PULSE_CYC(PULSE),
        .SETTLE_CYC(SETTLE), .SCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .apb(apb),
        .px0_adc_din(px0_adc_din), .px1_adc_din(px1_adc_din),
        .px2_adc_din(px2_adc_din), .px3_adc_din(px3_adc_din),
        .clk_px_read(clk),
        .px_adc_cs(px_adc_cs), .px_adc_sclk(px_adc_sclk),
        .resp(resp), .resv(resv), .incp(incp), .incv(incv), .inphi(inphi),
        .tp_startcap(tp_startcap), .tp_busy(tp_busy), .tp_wren(tp_wren),
        .tp_cam0_rden(tp_cam0_rden), .tp_cam0_full(tp_cam0_full),
        .tp_cam0_empty(tp_cam0_empty), .tp_cam0_afull(tp_cam0_afull),
        .tp_stateout(tp_stateout), .tp_substateout(tp_substateout),
        .TP_REG_OFFSET_UPPER_NIBBLE(tp_nibble)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Pixel 0 carries the hand-computed pattern; later pixels follow a simple formula.
    function automatic logic [15:0] sample(input int k, input int c);
        logic [15:0] v;
        if (k == 0) begin
            case (c)
                0:       v = 16'h0AB0;
                1:       v = 16'h0CD0;
                2:       v = 16'h0120;
                default: v = 16'h0340;
            endcase
        end else begin
            v = 16'(k * 16'h0917 + c * 16'h1351 + 16'h00F0);
        end
        return v;
    endfunction

    function automatic logic [31:0] pixel_word(input int k);
        logic [15:0] v0, v1, v2, v3;
        v0 = sample(k, 0); v1 = sample(k, 1); v2 = sample(k, 2); v3 = sample(k, 3);
        return {v3[11:4], v2[11:4], v1[11:4], v0[11:4]};
    endfunction

    // Model state: FIFO occupancy, ADC stream position, pulse/strobe counters.
    int   model_level = 0;
    logic exp_pop = 1'b0, exp_flush = 1'b0;
    logic wren_s = 1'b0, pop_s = 1'b0, flush_s = 1'b0;
    int   conv_k = 0, bit_idx = 15, rises = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    logic [3:0] pulse_now;
    int   plen [4];
    int   pcount [4];
    int   n_wren = 0, n_start = 0;
    logic [15:0] v0, v1, v2, v3;

    initial begin
        for (int i = 0; i < 4; i++) begin plen[i] = 0; pcount[i] = 0; end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_cs = 1'b1; prev_sclk = 1'b1;
            for (int i = 0; i < 4; i++) plen[i] = 0;
            wren_s = 1'b0; pop_s = 1'b0; flush_s = 1'b0;
        end else begin
            check("busy", 32'(tp_busy), 32'(tp_stateout != 4'd0));
            check("empty", 32'(tp_cam0_empty), 32'(model_level == 0));
            check("full", 32'(tp_cam0_full), 32'(model_level == DEPTH));
            check("afull", 32'(tp_cam0_afull), 32'(model_level >= DEPTH - 4));
            check("rden", 32'(tp_cam0_rden), 32'(exp_pop));
            check("inphi", 32'(inphi), 32'(resp));
            check("nibble", 32'(tp_nibble), 32'(apb.PADDR[7:4]));
            pulse_now = {incp, incv, resv, resp};
            for (int i = 0; i < 4; i++) begin
                if (pulse_now[i]) plen[i]++;
                else if (plen[i] != 0) begin
                    check("pulse_width", 32'(plen[i]), 32'(PULSE));
                    pcount[i]++;
                    plen[i] = 0;
                end
            end
            if (tp_wren) n_wren++;
            if (tp_startcap) n_start++;
            if (!px_adc_cs && prev_cs) begin bit_idx = 15; rises = 0; end
            if (px_adc_sclk && !prev_sclk && !prev_cs) rises++;
            if (!px_adc_sclk && prev_sclk && !px_adc_cs && bit_idx >= 0) begin
                v0 = sample(conv_k, 0); v1 = sample(conv_k, 1);
                v2 = sample(conv_k, 2); v3 = sample(conv_k, 3);
                px0_adc_din = v0[bit_idx]; px1_adc_din = v1[bit_idx];
                px2_adc_din = v2[bit_idx]; px3_adc_din = v3[bit_idx];
                bit_idx--;
            end
            if (px_adc_cs && !prev_cs) begin
                check("sclk_rises", 32'(rises), 32'd16);
                conv_k++;
            end
            prev_cs = px_adc_cs; prev_sclk = px_adc_sclk;
            wren_s = tp_wren; pop_s = exp_pop; flush_s = exp_flush;
        end
    end

    always @(posedge clk) begin
        if (reset) model_level = 0;
        else if (flush_s) model_level = wren_s ? 1 : 0;
        else model_level = model_level + int'(wren_s) - int'(pop_s);
    end

    logic [31:0] rd;
    logic        er;

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        if (!wr && addr[7:0] == 8'h04) exp_pop = (model_level != 0);
        if (wr && addr[7:0] == 8'h00 && wdata[1]) exp_flush = 1'b1;
        if (wr && addr[7:0] == 8'h00 && wdata[0] && !tp_busy) conv_k = 0;
        #3;
        rdata = apb.PRDATA; err = apb.PSLVERR;
        check("pready", 32'(apb.PREADY), 32'd1);
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; exp_pop = 1'b0; exp_flush = 1'b0;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return (tp_stateout == 4'd5) && tp_cam0_full;
            1:       return tp_cam0_full;
            2:       return !tp_cam0_empty;
            3:       return !tp_busy;
            4:       return (model_level >= 2) && (tp_stateout == 4'd4);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        int n = 0;
        while (!cond(which) && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (cond(which)) passes++;
        else $display("FAIL wait_%s: condition false after %0d cycles, required true", name, budget);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    int w;

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", 32'(px_adc_cs), 32'd1);
        check("rst_sclk", 32'(px_adc_sclk), 32'd1);
        check("rst_empty", 32'(tp_cam0_empty), 32'd1);
        check("rst_busy", 32'(tp_busy), 32'd0);
        check("rst_sensor", 32'({resp, resv, incp, incv, inphi}), 32'd0);
        check("rst_state", 32'(tp_stateout), 32'd0);
        check("rst_prdata", apb.PRDATA, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        apb_xfer(1'b0, 32'h08, 0, rd, er);
        check("rst_level", rd, 32'd0);
        check("rst_level_err", 32'(er), 32'd0);

        // Frame 1: no reads until the FIFO stalls the capture
        apb_xfer(1'b1, 32'h00, 32'h1, rd, er);
        check("start_err", 32'(er), 32'd0);
        wait_for(0, 3000, "stall");
        apb_xfer(1'b0, 32'h08, 0, rd, er);
        check("stall_level", rd, 32'd16);
        apb_xfer(1'b0, 32'h00, 0, rd, er);
        check("stall_ctrl", rd, 32'hD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", 32'(tp_stateout), 32'd5);
        end
        apb_xfer(1'b1, 32'hFFFF_FF00, 32'h1, rd, er);
        check("busy_start_err", 32'(er), 32'd0);
        apb_xfer(1'b0, 32'h0C, 0, rd, er);
        check("stall_pixcnt", rd, 32'd16);
        apb_xfer(1'b0, 32'h04, 0, rd, er);
        check("pix0_literal", rd, 32'h3412CDAB);
        check("pix0_model", rd, pixel_word(0));
        check("pix0_err", 32'(er), 32'd0);
        wait_for(1, 200, "refill");
        apb_xfer(1'b0, 32'h08, 0, rd, er);
        check("refill_level", rd, 32'd16);
        apb_xfer(1'b0, 32'h0C, 0, rd, er);
        check("refill_pixcnt", rd, 32'd17);
        for (int i = 1; i < NPIX - 2; i++) begin
            wait_for(2, 400, "data");
            apb_xfer(1'b0, 32'h04, 0, rd, er);
            check("data_word", rd, pixel_word(i));
            check("data_err", 32'(er), 32'd0);
        end
        wait_for(3, 2000, "frame_done");
        apb_xfer(1'b0, 32'h08, 0, rd, er);
        check("end_level", rd, 32'd2);
        apb_xfer(1'b0, 32'h0C, 0, rd, er);
        check("end_pixcnt", rd, 32'd25);
        check("cnt_resp", 32'(pcount[0]), 32'd1);
        check("cnt_resv", 32'(pcount[1]), 32'd5);
        check("cnt_incv", 32'(pcount[2]), 32'd20);
        check("cnt_incp", 32'(pcount[3]), 32'd4);
        check("cnt_wren", 32'(n_wren), 32'd25);
        check("cnt_startcap", 32'(n_start), 32'd1);

        // Flush and start in one write
        apb_xfer(1'b1, 32'h00, 32'h3, rd, er);
        check("flush_busy", 32'(tp_busy), 32'd1);
        apb_xfer(1'b0, 32'h08, 0, rd, er);
        check("flush_level", rd, 32'd0);
        apb_xfer(1'b0, 32'h0C, 0, rd, er);
        check("flush_pixcnt", rd, 32'd0);
        check("cnt_startcap2", 32'(n_start), 32'd2);

        // Reset during a conversion
        wait_for(4, 1500, "mid_conv");
        @(posedge clk); #1 reset = 1'b1;
        w = n_wren;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_state", 32'(tp_stateout), 32'd0);
        check("mid_rst_cs", 32'(px_adc_cs), 32'd1);
        check("mid_rst_sclk", 32'(px_adc_sclk), 32'd1);
        check("mid_rst_empty", 32'(tp_cam0_empty), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_rst_no_wren", 32'(n_wren), 32'(w));
        check("mid_rst_idle", 32'(tp_busy), 32'd0);

        // Error paths
        apb_xfer(1'b0, 32'h04, 0, rd, er);
        check("empty_read_data", rd, 32'd0);
        check("empty_read_err", 32'(er), 32'd1);
        apb_xfer(1'b0, 32'h10, 0, rd, er);
        check("bad_addr_err", 32'(er), 32'd1);
        check("bad_addr_data", rd, 32'd0);
        apb_xfer(1'b1, 32'h08, 32'h5, rd, er);
        check("ro_write_err", 32'(er), 32'd1);
        apb_xfer(1'b0, 32'h1234_56A8, 0, rd, er);
        check("nibble_err", 32'(er), 32'd1);
        check("nibble_lit", 32'(tp_nibble), 32'hA);
        apb_xfer(1'b0, 32'h00, 0, rd, er);
        check("idle_ctrl", rd, 32'h2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
